// File: rtl/alu_multicycle.sv
// alu_multicycle: WIDTH-bit ALU with valid/ready handshakes on both sides.
//   Single-cycle ops (ADD/SUB/OR/AND/XOR/SLT) produce a result one cycle
//   after accept; MULU (shift-add) and DIVU (restoring) iterate WIDTH cycles.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake (op, a, b)
//   out_valid/out_ready  result handshake (result, zero, overflow, dbz)
module alu_multicycle #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             dbz
);

  localparam int unsigned MSB   = WIDTH - 1;
  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;     // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // mul: multiplicand; div: divisor
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic [WIDTH-1:0]   sum, diff;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [ACC_W-1:0]   iter_next;
  logic               accept;

  // Single-cycle operation datapath.
  always_comb begin
    sum     = a + b;
    diff    = a - b;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  // One shift-add or restoring-divide step on the accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[ACC_W-1:WIDTH], acc_q[MSB]};
    div_diff  = div_shift - {1'b0, opnd_q};
    // A zero divisor always "fits", which yields the all-ones quotient.
    div_ge    = !div_diff[WIDTH] || (opnd_q == '0);
    if (is_div_q) begin
      iter_next = {(div_ge ? div_diff[MSB:0] : div_shift[MSB:0]), acc_q[MSB-1:0], div_ge};
    end else begin
      iter_next = {mul_sum, acc_q[MSB:1]};
    end
  end

  // Next-state and handshake logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    in_ready = 1'b0;
    accept   = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      BUSY: begin
        acc_d = iter_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = iter_next[MSB:0];
          zero_d   = (iter_next[MSB:0] == '0);
          ovf_d    = !is_div_q && (iter_next[ACC_W-1:WIDTH] != '0);
          dbz_d    = is_div_q && (opnd_q == '0);
          state_d  = HOLD;
        end
      end
      HOLD: begin
        in_ready = out_ready;
        if (out_ready) begin
          state_d = IDLE;
          accept  = in_valid;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept from IDLE or from HOLD while the old result is consumed.
    if (accept) begin
      if (op[2:1] == 2'b11) begin
        is_div_d = op[0];
        opnd_d   = op[0] ? b : a;
        acc_d    = {{WIDTH{1'b0}}, (op[0] ? a : b)};
        cnt_d    = CNT_W'(WIDTH);
        state_d  = BUSY;
      end else begin
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        ovf_d    = alu_ovf;
        dbz_d    = 1'b0;
        state_d  = HOLD;
      end
    end

    if (rst) begin
      in_ready = 1'b0;
    end
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: a 32-bit and an 8-bit instance checked every
// cycle against a transaction-level reference model, plus literal checks.
module tb_alu_multicycle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic [1:0]       in_valid_v = '0;
  logic [2:0]       op_s [2];
  logic [63:0]      a_s  [2];
  logic [63:0]      b_s  [2];
  logic [1:0]       or_man = 2'b11;
  logic [1:0]       or_rnd = 2'b11;
  logic             rnd_mode = 1'b0;
  logic [1:0]       or_v;
  logic             in_ready0, in_ready1, out_valid0, out_valid1;
  logic             zero0, zero1, ovf0, ovf1, dbz0, dbz1;
  logic [31:0]      res32;
  logic [7:0]       res8;
  logic [1:0]       in_ready_v, out_valid_v, zero_v, ovf_v, dbz_v;

  assign or_v        = rnd_mode ? or_rnd : or_man;
  assign in_ready_v  = {in_ready1, in_ready0};
  assign out_valid_v = {out_valid1, out_valid0};
  assign zero_v      = {zero1, zero0};
  assign ovf_v       = {ovf1, ovf0};
  assign dbz_v       = {dbz1, dbz0};

  alu_multicycle #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready0),
    .op(op_s[0]), .a(a_s[0][31:0]), .b(b_s[0][31:0]),
    .out_valid(out_valid0), .out_ready(or_v[0]), .result(res32),
    .zero(zero0), .overflow(ovf0), .dbz(dbz0)
  );

  alu_multicycle #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready1),
    .op(op_s[1]), .a(a_s[1][7:0]), .b(b_s[1][7:0]),
    .out_valid(out_valid1), .out_ready(or_v[1]), .result(res8),
    .zero(zero1), .overflow(ovf1), .dbz(dbz1)
  );

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, OR_ = 3'd2, AND_ = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4, SLT = 3'd5, MULU = 3'd6, DIVU = 3'd7;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wid(input int i);
    return (i == 0) ? 32 : 8;
  endfunction

  function automatic logic [63:0] wmask(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] dut_res(input int i);
    return (i == 0) ? {32'd0, res32} : {56'd0, res8};
  endfunction

  task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (w%0d) t=%0t: got %0h, expected %0h", name, wid(i), $time, act, exp);
    end
  endtask

  task automatic tfail(input string name, input int i);
    n_checks++;
    n_fail++;
    $display("FAIL %s (w%0d) t=%0t: bound expired", name, wid(i), $time);
  endtask

  // Reference arithmetic, straight from the operation definitions.
  function automatic void ref_op(input logic [2:0] op, input logic [63:0] a_in, input logic [63:0] b_in,
                                 input int w, output logic [63:0] r, output logic ov, output logic dz);
    logic [63:0]  m, a, b;
    logic [127:0] p;
    longint       sa, sb;
    m  = wmask(w);
    a  = a_in & m;
    b  = b_in & m;
    sa = longint'(a << (64 - w)) >>> (64 - w);
    sb = longint'(b << (64 - w)) >>> (64 - w);
    p  = {64'd0, a} * {64'd0, b};
    ov = 1'b0;
    dz = 1'b0;
    case (op)
      ADD: begin r = (a + b) & m; ov = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]); end
      SUB: begin r = (a - b) & m; ov = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]); end
      OR_:  r = a | b;
      AND_: r = a & b;
      XOR_: r = a ^ b;
      SLT:  r = (sa < sb) ? 64'd1 : 64'd0;
      MULU: begin r = p[63:0] & m; ov = ((p >> w) != 128'd0); end
      default: begin
        if (b == 64'd0) begin r = m; dz = 1'b1; end
        else r = a / b;
      end
    endcase
  endfunction

  // Transaction-level model: what each output must be after every edge.
  logic        started = 1'b0;
  logic        m_valid [2];
  logic [63:0] m_res   [2];
  logic        m_zero  [2], m_ovf [2], m_dbz [2];
  int          m_busy  [2];
  logic [63:0] p_res   [2];
  logic        p_ovf   [2], p_dbz [2];

  initial begin
    logic [63:0] r;
    logic ov, dz, rdy;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0; m_res[i] = '0; m_zero[i] = 1'b0; m_ovf[i] = 1'b0;
      m_dbz[i] = 1'b0; m_busy[i] = 0; p_res[i] = '0; p_ovf[i] = 1'b0; p_dbz[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          m_valid[i] = 1'b0; m_res[i] = '0; m_zero[i] = 1'b0;
          m_ovf[i] = 1'b0; m_dbz[i] = 1'b0; m_busy[i] = 0;
        end else if (m_busy[i] > 0) begin
          m_busy[i]--;
          if (m_busy[i] == 0) begin
            m_valid[i] = 1'b1; m_res[i] = p_res[i]; m_zero[i] = (p_res[i] == 64'd0);
            m_ovf[i] = p_ovf[i]; m_dbz[i] = p_dbz[i];
          end
        end else begin
          rdy = !m_valid[i] || or_v[i];
          if (m_valid[i] && or_v[i]) m_valid[i] = 1'b0;
          if (in_valid_v[i] && rdy) begin
            ref_op(op_s[i], a_s[i], b_s[i], wid(i), r, ov, dz);
            if (op_s[i] == MULU || op_s[i] == DIVU) begin
              m_busy[i] = wid(i); p_res[i] = r; p_ovf[i] = ov; p_dbz[i] = dz;
            end else begin
              m_valid[i] = 1'b1; m_res[i] = r; m_zero[i] = (r == 64'd0);
              m_ovf[i] = ov; m_dbz[i] = dz;
            end
          end
        end
      end
      if (rst) started = 1'b1;
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk("in_ready", i, 64'(in_ready_v[i]),
            64'(!rst && m_busy[i] == 0 && (!m_valid[i] || or_v[i])));
        chk("out_valid", i, 64'(out_valid_v[i]), 64'(m_valid[i]));
        chk("result",    i, dut_res(i),          m_res[i]);
        chk("zero",      i, 64'(zero_v[i]),      64'(m_zero[i]));
        chk("overflow",  i, 64'(ovf_v[i]),       64'(m_ovf[i]));
        chk("dbz",       i, 64'(dbz_v[i]),       64'(m_dbz[i]));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    or_rnd <= {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
  end

  // Called and returns at posedge+1; holds in_valid until the transfer edge.
  task automatic send(input int i, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    in_valid_v[i] = 1'b1; op_s[i] = op; a_s[i] = a; b_s[i] = b;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready_v[i]) begin
        @(posedge clk); #1;
        in_valid_v[i] = 1'b0;
        a_s[i] = {$urandom, $urandom};
        b_s[i] = {$urandom, $urandom};
        op_s[i] = 3'($urandom_range(0, 7));
        return;
      end
      @(posedge clk); #1;
    end
    in_valid_v[i] = 1'b0;
    tfail("send_timeout", i);
  endtask

  // Counts negedges after the transfer edge until out_valid is seen.
  task automatic wait_out(input int i, output int n);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      n++;
      if (out_valid_v[i]) break;
    end
    if (!out_valid_v[i]) tfail("out_timeout", i);
  endtask

  task automatic dir(input int i, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] er, input logic ez, input logic eo, input logic ed, input int elat);
    int n;
    send(i, op, a, b);
    wait_out(i, n);
    chk("lit_result",   i, dut_res(i),        er);
    chk("lit_zero",     i, 64'(zero_v[i]),    64'(ez));
    chk("lit_overflow", i, 64'(ovf_v[i]),     64'(eo));
    chk("lit_dbz",      i, 64'(dbz_v[i]),     64'(ed));
    chk("lit_latency",  i, 64'(n),            64'(elat));
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rand_opnd(input int w);
    logic [63:0] m;
    m = wmask(w);
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'd1;
      2: return m;
      3: return 64'd1 << (w - 1);
      4: return (64'd1 << (w - 1)) - 64'd1;
      5: return 64'($urandom_range(0, 15));
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  initial begin
    int n, c0;
    for (int i = 0; i < 2; i++) begin op_s[i] = '0; a_s[i] = '0; b_s[i] = '0; end
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 0, 64'(in_ready_v[0]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready",  0, 64'(in_ready_v[0]),  64'd1);
    chk("reset_out_valid", 0, 64'(out_valid_v[0]), 64'd0);
    chk("reset_result",    0, dut_res(0),          64'd0);
    chk("reset_zero",      0, 64'(zero_v[0]),      64'd0);
    @(posedge clk); #1;

    // 32-bit directed sequence, out_ready held high.
    dir(0, ADD,  64'h10,       64'h20,       64'h30,       0, 0, 0, 1);
    dir(0, SUB,  64'h30,       64'h30,       64'h0,        1, 0, 0, 1);
    dir(0, OR_,  64'hFF00FF00, 64'h00FF00FF, 64'hFFFFFFFF, 0, 0, 0, 1);
    dir(0, SLT,  64'hFFFFFFFF, 64'h1,        64'h1,        0, 0, 0, 1);
    dir(0, ADD,  64'h7FFFFFFF, 64'h1,        64'h80000000, 0, 1, 0, 1);
    dir(0, SUB,  64'h80000000, 64'h1,        64'h7FFFFFFF, 0, 1, 0, 1);
    dir(0, MULU, 64'h00010000, 64'h00010000, 64'h0,        1, 1, 0, 33);
    dir(0, MULU, 64'd12,       64'd11,       64'd132,      0, 0, 0, 33);
    dir(0, DIVU, 64'd100,      64'd7,        64'd14,       0, 0, 0, 33);
    dir(0, DIVU, 64'd5,        64'd0,        64'hFFFFFFFF, 0, 0, 1, 33);

    // Back-to-back single-cycle ops: one transfer per cycle.
    c0 = cyc;
    send(0, AND_, 64'hF0F0, 64'h0FF0);
    send(0, XOR_, 64'h1234, 64'h1234);
    send(0, ADD,  64'd1,    64'd2);
    send(0, SUB,  64'd9,    64'd4);
    chk("b2b_cycles", 0, 64'(cyc - c0), 64'd4);
    repeat (2) @(posedge clk); #1;

    // Backpressure, then consume and accept on the same edge.
    or_man[0] = 1'b0;
    send(0, ADD, 64'd1, 64'd2);
    wait_out(0, n);
    @(posedge clk); #1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_result",   0, dut_res(0),         64'd3);
      chk("bp_in_ready", 0, 64'(in_ready_v[0]), 64'd0);
      @(posedge clk); #1;
    end
    or_man[0] = 1'b1;
    send(0, XOR_, 64'hF0F0, 64'h0FF0);
    wait_out(0, n);
    chk("bp_next_result",  0, dut_res(0), 64'h0000FF00);
    chk("bp_next_latency", 0, 64'(n),     64'd1);
    @(posedge clk); #1;

    // Reset in the middle of a multiply.
    send(0, MULU, 64'h1234, 64'h5678);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready",  0, 64'(in_ready_v[0]),  64'd1);
    chk("mid_rst_out_valid", 0, 64'(out_valid_v[0]), 64'd0);
    chk("mid_rst_result",    0, dut_res(0),          64'd0);
    chk("mid_rst_flags",     0, {61'd0, zero_v[0], ovf_v[0], dbz_v[0]}, 64'd0);
    @(posedge clk); #1;
    repeat (40) @(posedge clk); #1;
    dir(0, ADD, 64'd5, 64'd6, 64'd11, 0, 0, 0, 1);

    // 8-bit instance.
    dir(1, ADD,  64'h7F, 64'h01, 64'h80, 0, 1, 0, 1);
    dir(1, MULU, 64'd12, 64'd11, 64'd132, 0, 0, 0, 9);
    dir(1, MULU, 64'h20, 64'h10, 64'h00, 1, 1, 0, 9);
    dir(1, DIVU, 64'd200, 64'd0, 64'hFF, 0, 0, 1, 9);
    dir(1, SLT,  64'h80, 64'h01, 64'h01, 0, 0, 0, 1);

    // Randomized traffic with random consumer backpressure.
    rnd_mode = 1'b1;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 150; k++) begin
        send(i, 3'($urandom_range(0, 7)), rand_opnd(wid(i)), rand_opnd(wid(i)));
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
    end
    rnd_mode = 1'b0;
    repeat (60) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
